// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// LEADING_ZERO_BLANK_EN enables auto-blanking of leading zero base digits.
package display_pkg;

    localparam int DIGITS   = 4;
    localparam int NIBBLE_W = 4;
    localparam int SEG_W    = 7;

    typedef enum logic [1:0] {
        BASE,
        PEND,
        MSG
    } state_e;

    // seg[6]=a ... seg[0]=g, indexed by hex value
    localparam logic [0:15][SEG_W-1:0] SEG_LUT = {
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic logic [DIGITS-1:0] lzb_mask(
        input logic [DIGITS*NIBBLE_W-1:0] v
    );
        logic [DIGITS-1:0] m;
        m    = '0;
        m[3] = (v[15:12] == 4'h0);
        m[2] = m[3] && (v[11:8] == 4'h0);
        m[1] = m[2] && (v[7:4] == 4'h0);
        return m;
    endfunction

endpackage

// File: rtl/hex_to_segments.sv
// Combinational hex nibble to active-high segment decode.
module hex_to_segments
    import display_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble_i,
    output logic [SEG_W-1:0]    seg_o
);

    assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit scan scheduler with base/message arbitration.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero base digits.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int MSG_FRAMES = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] base_val,
    input  logic [3:0]  base_blank,
    input  logic        msg_req,
    input  logic [15:0] msg_val,
    output logic        msg_ack,
    output logic        msg_active,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic [3:0]  digit
);

    localparam logic [15:0] PRE_MAX   = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  HOLD_INIT = 8'(MSG_FRAMES - 1);

    logic [15:0] pre_q, pre_d;
    logic [1:0]  idx_q, idx_d;
    logic        init_q;
    state_e      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        reload_q, reload_d;
    logic [15:0] msg_buf_q, msg_buf_d;
    logic        ack_q;
    logic        snap_msg_q, snap_msg_d;
    logic [15:0] snap_val_q, snap_val_d;
    logic [3:0]  snap_blank_q, snap_blank_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  digit_q, digit_d;

    logic        tick;
    logic        frame_end;
    logic        snap_en;
    logic [3:0]  base_blank_eff;
    logic [3:0]  sel_nib;
    logic        sel_blank;
    logic [6:0]  dec_seg;

    assign tick      = (pre_q == PRE_MAX);
    assign frame_end = tick && (idx_q == 2'd3);
    assign snap_en   = frame_end || !init_q;

`ifdef LEADING_ZERO_BLANK_EN
    assign base_blank_eff = base_blank | lzb_mask(base_val);
`else
    assign base_blank_eff = base_blank;
`endif

    assign sel_nib   = snap_val_q[{idx_q, 2'b00} +: NIBBLE_W];
    assign sel_blank = snap_blank_q[idx_q];

    hex_to_segments u_dec (
        .nibble_i (sel_nib),
        .seg_o    (dec_seg)
    );

    always_comb begin
        pre_d = tick ? 16'd0 : pre_q + 16'd1;
        idx_d = tick ? idx_q + 2'd1 : idx_q;
    end

    // A re-request in MSG restarts the full hold from the next frame,
    // so the frame_end that closes the current frame must not decrement.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        reload_d  = reload_q;
        msg_buf_d = msg_req ? msg_val : msg_buf_q;
        unique case (state_q)
            BASE: begin
                reload_d = 1'b0;
                if (msg_req) state_d = PEND;
            end
            PEND: begin
                if (frame_end) begin
                    state_d  = MSG;
                    hold_d   = HOLD_INIT;
                    reload_d = 1'b0;
                end
            end
            MSG: begin
                if (frame_end) begin
                    reload_d = 1'b0;
                    if (msg_req || reload_q) begin
                        hold_d = HOLD_INIT;
                    end else if (hold_q == 8'd0) begin
                        state_d = BASE;
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end else if (msg_req) begin
                    hold_d   = HOLD_INIT;
                    reload_d = 1'b1;
                end
            end
            default: state_d = BASE;
        endcase
    end

    always_comb begin
        snap_msg_d   = snap_msg_q;
        snap_val_d   = snap_val_q;
        snap_blank_d = snap_blank_q;
        if (snap_en) begin
            snap_msg_d   = (state_d == MSG);
            snap_val_d   = snap_msg_d ? msg_buf_d : base_val;
            snap_blank_d = snap_msg_d ? 4'h0 : base_blank_eff;
        end
    end

    always_comb begin
        an_d    = an_q;
        seg_d   = seg_q;
        digit_d = digit_q;
        if (tick) begin
            an_d    = sel_blank ? 4'hF : ~(4'b0001 << idx_q);
            seg_d   = sel_blank ? 7'h00 : dec_seg;
            digit_d = sel_nib;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q        <= '0;
            idx_q        <= '0;
            init_q       <= 1'b0;
            state_q      <= BASE;
            hold_q       <= '0;
            reload_q     <= 1'b0;
            msg_buf_q    <= '0;
            ack_q        <= 1'b0;
            snap_msg_q   <= 1'b0;
            snap_val_q   <= '0;
            snap_blank_q <= '0;
            an_q         <= 4'hF;
            seg_q        <= '0;
            digit_q      <= '0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            init_q       <= 1'b1;
            state_q      <= state_d;
            hold_q       <= hold_d;
            reload_q     <= reload_d;
            msg_buf_q    <= msg_buf_d;
            ack_q        <= msg_req;
            snap_msg_q   <= snap_msg_d;
            snap_val_q   <= snap_val_d;
            snap_blank_q <= snap_blank_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            digit_q      <= digit_d;
        end
    end

    assign msg_ack    = ack_q;
    assign msg_active = (state_q == MSG);
    assign an         = an_q;
    assign seg        = seg_q;
    assign digit      = digit_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SCAN_DIV=4, MSG_FRAMES=2.
module tb_display_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] base_val;
    logic [3:0]  base_blank;
    logic        msg_req;
    logic [15:0] msg_val;
    logic        msg_ack;
    logic        msg_active;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [3:0]  digit;

    int n_chk;
    int n_pass;
    int act_cnt;
    logic cnt_en;

    display_scan_ctrl #(
        .SCAN_DIV   (4),
        .MSG_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .base_val   (base_val),
        .base_blank (base_blank),
        .msg_req    (msg_req),
        .msg_val    (msg_val),
        .msg_ack    (msg_ack),
        .msg_active (msg_active),
        .an         (an),
        .seg        (seg),
        .digit      (digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (cnt_en && msg_active) act_cnt++;

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic chk_slot(input string tag, input logic [3:0] e_an,
                            input logic [6:0] e_seg, input logic [3:0] e_dig);
        chk({tag, ".an"}, {12'h0, an}, {12'h0, e_an});
        chk({tag, ".seg"}, {9'h0, seg}, {9'h0, e_seg});
        chk({tag, ".digit"}, {12'h0, digit}, {12'h0, e_dig});
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        act_cnt    = 0;
        cnt_en     = 1'b0;
        rst_n      = 1'b0;
        base_val   = 16'h12AF;
        base_blank = 4'h0;
        msg_req    = 1'b0;
        msg_val    = 16'h0000;

        #12;
        chk_slot("rst", 4'b1111, 7'b0000000, 4'h0);
        chk("rst.active", {15'h0, msg_active}, 16'h0);
        chk("rst.ack", {15'h0, msg_ack}, 16'h0);
        rst_n = 1'b1;

        tick_n(3);
        chk("pre_tick.an", {12'h0, an}, 16'h000F);
        tick_n(1);
        chk_slot("s0", 4'b1110, 7'b1000111, 4'hF);
        tick_n(3);
        chk("s0_hold.an", {12'h0, an}, 16'h000E);
        tick_n(1);
        chk_slot("s1", 4'b1101, 7'b1110111, 4'hA);
        tick_n(4);
        chk_slot("s2", 4'b1011, 7'b1101101, 4'h2);
        tick_n(4);
        chk_slot("s3", 4'b0111, 7'b0110000, 4'h1);

        tick_n(2);
        msg_val = 16'hC0FE;
        msg_req = 1'b1;
        tick_n(1);
        msg_req = 1'b0;
        chk("m1.ack", {15'h0, msg_ack}, 16'h1);
        chk("m1.pend_active", {15'h0, msg_active}, 16'h0);
        tick_n(1);
        chk("m1.ack_off", {15'h0, msg_ack}, 16'h0);
        chk("m1.base_still", {12'h0, digit}, 16'h000F);
        cnt_en = 1'b1;
        tick_n(12);
        chk("m1.active", {15'h0, msg_active}, 16'h1);
        chk("m1.base_s3", {12'h0, digit}, 16'h0001);
        tick_n(4);
        chk_slot("m1s0", 4'b1110, 7'b1001111, 4'hE);
        tick_n(4);
        chk_slot("m1s1", 4'b1101, 7'b1000111, 4'hF);
        tick_n(4);
        chk_slot("m1s2", 4'b1011, 7'b1111110, 4'h0);
        tick_n(4);
        chk_slot("m1s3", 4'b0111, 7'b1001110, 4'hC);
        tick_n(16);
        chk("m1.end_active", {15'h0, msg_active}, 16'h0);
        chk("m1.last_slot", {12'h0, digit}, 16'h000C);
        tick_n(4);
        chk_slot("m1.base_back", 4'b1110, 7'b1000111, 4'hF);
        tick_n(12);
        cnt_en = 1'b0;
        chk("m1.active_cycles", act_cnt[15:0], 16'd32);

        msg_req = 1'b1;
        tick_n(1);
        msg_req = 1'b0;
        chk("m2.ack", {15'h0, msg_ack}, 16'h1);
        tick_n(15);
        chk("m2.active", {15'h0, msg_active}, 16'h1);
        tick_n(4);
        chk("m2.s0", {12'h0, digit}, 16'h000E);
        msg_val = 16'hE000;
        msg_req = 1'b1;
        tick_n(1);
        msg_req = 1'b0;
        chk("m2.reack", {15'h0, msg_ack}, 16'h1);
        tick_n(3);
        chk("m2.old_s1", {12'h0, digit}, 16'h000F);
        tick_n(12);
        chk_slot("m2.new_s0", 4'b1110, 7'b1111110, 4'h0);
        tick_n(12);
        chk("m2.hold_active", {15'h0, msg_active}, 16'h1);
        tick_n(4);
        chk("m2.f2_active", {15'h0, msg_active}, 16'h1);
        chk("m2.f2_s0", {12'h0, digit}, 16'h0000);
        tick_n(12);
        chk("m2.end_active", {15'h0, msg_active}, 16'h0);
        tick_n(4);
        chk_slot("m2.base_back", 4'b1110, 7'b1000111, 4'hF);

        base_val   = 16'h0045;
        base_blank = 4'b1000;
        tick_n(4);
        chk_slot("coh.s1", 4'b1101, 7'b1110111, 4'hA);
        tick_n(12);
        chk_slot("b.s0", 4'b1110, 7'b1011011, 4'h5);
        tick_n(4);
        chk_slot("b.s1", 4'b1101, 7'b0110011, 4'h4);
        tick_n(4);
`ifdef LEADING_ZERO_BLANK_EN
        chk_slot("b.s2", 4'b1111, 7'b0000000, 4'h0);
`else
        chk_slot("b.s2", 4'b1011, 7'b1111110, 4'h0);
`endif
        tick_n(4);
        chk_slot("b.s3", 4'b1111, 7'b0000000, 4'h0);

        msg_val = 16'hC0FE;
        msg_req = 1'b1;
        tick_n(1);
        msg_req = 1'b0;
        tick_n(15);
        chk("m3.active", {15'h0, msg_active}, 16'h1);
        tick_n(16);
        chk_slot("m3.noblank_s3", 4'b0111, 7'b1001110, 4'hC);

        #3;
        rst_n = 1'b0;
        #1;
        chk_slot("arst", 4'b1111, 7'b0000000, 4'h0);
        chk("arst.active", {15'h0, msg_active}, 16'h0);
        chk("arst.ack", {15'h0, msg_ack}, 16'h0);
        #2;
        rst_n = 1'b1;
        tick_n(4);
        chk_slot("post.s0", 4'b1110, 7'b1011011, 4'h5);
        chk("post.active", {15'h0, msg_active}, 16'h0);
        tick_n(32);
        chk("post.idle_active", {15'h0, msg_active}, 16'h0);
        chk("post.idle_ack", {15'h0, msg_ack}, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
